button_pulse_gen: RTL and testbench



---
 rtl/button_pulse_gen.sv | 59 +++++
 tb/tb_button_pulse_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronizes and debounces raw pushbuttons, then emits one
// {1'b1, index} code per accepted press, lowest index first.
module button_pulse_gen #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [4:0]           buttonPulse,
    output logic                 busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [N_BUTTONS-1:0]          sync1_q, sync2_q, acc_q, acc_d, pend_q, pend_d, grant, rise;
    logic [N_BUTTONS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]                    idx;
    logic [4:0]                    pulse_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = (sync2_q[i] == acc_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + CNT_ONE;
            acc_d[i] = (sync2_q[i] != acc_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : acc_q[i];
        end
        rise = acc_d & ~acc_q;
        idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--)
            if (pend_q[i]) idx = 4'(i);
        // Isolate the lowest set pending bit; a fresh rise on that bit re-arms it.
        grant   = pend_q & (~pend_q + N_BUTTONS'(1));
        pend_d  = (pend_q & ~grant) | rise;
        pulse_d = (|pend_q) ? {1'b1, idx} : 5'b00000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            buttonPulse <= 5'b00000;
            busy        <= 1'b0;
        end else begin
            sync1_q     <= buttons ^ {N_BUTTONS{ACTIVE_LOW}};
            sync2_q     <= sync1_q;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            buttonPulse <= pulse_d;
            busy        <= |pend_d;
        end
    end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: directed plan plus random stimulus, checked each cycle
// against a window-based reference model of debounce and press arbitration.
module tb_button_pulse_gen;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] buttons = 4'hF;
    logic [4:0] buttonPulse;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int n_edge = 0;
    int n0;

    logic [3:0] hist[$];
    logic [3:0] m_acc, m_pend;
    logic [4:0] exp_pulse;
    logic       exp_busy;
    logic [4:0] obs_val[$];
    int         obs_edge[$];

    button_pulse_gen #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .buttons(buttons), .buttonPulse(buttonPulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_back(4'h0);
        m_acc = '0;
        m_pend = '0;
    endtask

    // A level is accepted once the last D synchronized samples all disagree with the accepted one.
    task automatic model_step(input logic [3:0] pins);
        logic [3:0] rise;
        logic       all_diff, found;
        rise = '0;
        found = 1'b0;
        exp_pulse = 5'b00000;
        for (int i = 0; i < 4; i++)
            if (!found && m_pend[i]) begin
                found = 1'b1;
                exp_pulse = {1'b1, 4'(i)};
                m_pend[i] = 1'b0;
            end
        hist.push_front(~pins);
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 2; j < D + 2; j++)
                if (hist[j][i] == m_acc[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_acc[i] = ~m_acc[i];
                if (m_acc[i]) rise[i] = 1'b1;
            end
        end
        void'(hist.pop_back());
        m_pend = m_pend | rise;
        exp_busy = |m_pend;
    endtask

    task automatic cyc(input logic [3:0] v);
        buttons = v;
        @(posedge clk);
        #1;
        n_edge++;
        model_step(v);
        check("pulse", buttonPulse, exp_pulse);
        check("busy", busy, exp_busy);
        if (buttonPulse != 5'b00000) begin
            obs_val.push_back(buttonPulse);
            obs_edge.push_back(n_edge);
        end
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int k = 0; k < n; k++) cyc(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_pulse", buttonPulse, 5'b00000);
        check("rst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_edge = 0;
    endtask

    task automatic clear_obs();
        obs_val.delete();
        obs_edge.delete();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(4'hF, 20);

        clear_obs();
        n0 = n_edge;
        hold(4'b1011, 15);
        check("pb2_count", obs_val.size(), 1);
        check("pb2_code", (obs_val.size() > 0) ? obs_val[0] : 5'h0, 5'b10010);
        check("pb2_latency", (obs_edge.size() > 0) ? obs_edge[0] - n0 : 0, 7);
        clear_obs();
        hold(4'hF, 15);
        check("pb2_release", obs_val.size(), 0);

        clear_obs();
        hold(4'b1101, 2);
        hold(4'b1111, 1);
        hold(4'b1101, 3);
        hold(4'b1111, 12);
        check("bounce", obs_val.size(), 0);

        clear_obs();
        hold(4'b0100, 15);
        check("sim_count", obs_val.size(), 3);
        check("sim_0", (obs_val.size() > 2) ? obs_val[0] : 5'h0, 5'b10000);
        check("sim_1", (obs_val.size() > 2) ? obs_val[1] : 5'h0, 5'b10001);
        check("sim_2", (obs_val.size() > 2) ? obs_val[2] : 5'h0, 5'b10011);
        check("sim_consec", (obs_edge.size() > 2) ? obs_edge[2] - obs_edge[0] : 0, 2);
        hold(4'hF, 12);

        clear_obs();
        hold(4'b0111, 5);
        check("mid_none", obs_val.size(), 0);
        do_reset();
        clear_obs();
        hold(4'b0111, 15);
        check("mid_count", obs_val.size(), 1);
        check("mid_code", (obs_val.size() > 0) ? obs_val[0] : 5'h0, 5'b10011);
        check("mid_latency", (obs_edge.size() > 0) ? obs_edge[0] : 0, 7);
        hold(4'hF, 12);

        clear_obs();
        hold(4'b1110, 4);
        hold(4'b1111, 4);
        hold(4'b1110, 12);
        check("rep_count", obs_val.size(), 2);
        check("rep_a", (obs_val.size() > 1) ? obs_val[0] : 5'h0, 5'b10000);
        check("rep_b", (obs_val.size() > 1) ? obs_val[1] : 5'h0, 5'b10000);
        check("rep_gap", (obs_edge.size() > 1) ? int'(obs_edge[1] > obs_edge[0] + 1) : 0, 1);
        hold(4'hF, 12);

        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 14) == 0) do_reset();
            hold(4'($urandom), $urandom_range(1, 10));
        end
        hold(4'hF, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
